fft_bin_serializer: RTL and testbench

FFT_BIN_SERIALIZER -- requirements
Module: fft_bin_serializer

---
 rtl/fft_bin_serializer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fft_bin_serializer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bin_serializer.sv
// rtl/fft_bin_serializer.sv - two-bank FFT bin reorder buffer with AXI-Stream style output
module fft_bin_serializer #(
    parameter int LOG2_NSUB = 14,
    parameter int K_WIDTH   = 14
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [63:0]            in_data_0,
    input  logic [63:0]            in_data_1,
    input  logic [63:0]            in_data_2,
    input  logic [63:0]            in_data_3,
    input  logic [K_WIDTH-1:0]     in_k,
    input  logic                   in_valid,
    output logic [63:0]            m_tdata,
    output logic [LOG2_NSUB+1:0]   m_tuser,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [15:0]            frame_drop_cnt,
    output logic                   sync_err
);

    localparam int NSUB = 1 << LOG2_NSUB;
    localparam int BW   = LOG2_NSUB + 2;
    localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(NSUB - 1);
    localparam logic [BW-1:0]      B_LAST = BW'(4 * NSUB - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    typedef enum logic [1:0] {
        WR_SYNC,
        WR_WRITE,
        WR_DROP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_DRAIN
    } rd_state_e;

    // Frame storage: bank x lane x sub-bin; contents survive reset
    logic [63:0] mem [2][4][NSUB];

    bank_state_e         bank_q [2];
    bank_state_e         bank_r [2];
    bank_state_e         bank_d [2];

    wr_state_e           wr_state_q, wr_state_d;
    logic                wr_bank_q, wr_bank_d;
    logic [K_WIDTH-1:0]  exp_k_q, exp_k_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                sync_err_q, sync_err_d;

    rd_state_e           rd_state_q, rd_state_d;
    logic                rd_bank_q, rd_bank_d;
    logic [63:0]         tdata_q, tdata_d;
    logic [BW-1:0]       tuser_q, tuser_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;

    logic                rd_claim;
    logic                ld_en;
    logic                ld_bank;
    logic [BW-1:0]       ld_b;

    logic                begin_frame;
    logic                accept;
    logic                acc_bank;
    logic                drop_done;

    // Reader: pick a FULL bank, walk b = lane*NSUB + k, release bank on final handshake
    always_comb begin
        bank_r     = bank_q;
        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tuser_d    = tuser_q;
        tlast_d    = tlast_q;
        rd_claim   = 1'b0;
        ld_en      = 1'b0;
        ld_bank    = rd_bank_q;
        ld_b       = '0;

        case (rd_state_q)
            RD_IDLE: begin
                // Two FULL banks at once cannot occur while idle, so A-first is safe
                if (bank_q[0] == BANK_FULL) begin
                    rd_claim = 1'b1;
                    ld_bank  = 1'b0;
                end else if (bank_q[1] == BANK_FULL) begin
                    rd_claim = 1'b1;
                    ld_bank  = 1'b1;
                end
            end
            RD_DRAIN: begin
                if (tvalid_q && m_tready) begin
                    if (tuser_q == B_LAST) begin
                        bank_r[rd_bank_q] = BANK_EMPTY;
                        if (bank_q[~rd_bank_q] == BANK_FULL) begin
                            // Chain straight into the waiting frame with no bubble
                            rd_claim = 1'b1;
                            ld_bank  = ~rd_bank_q;
                        end else begin
                            rd_state_d = RD_IDLE;
                            tvalid_d   = 1'b0;
                            tlast_d    = 1'b0;
                        end
                    end else begin
                        ld_en   = 1'b1;
                        ld_bank = rd_bank_q;
                        ld_b    = tuser_q + BW'(1);
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        if (rd_claim) begin
            bank_r[ld_bank] = BANK_DRAINING;
            rd_bank_d       = ld_bank;
            rd_state_d      = RD_DRAIN;
            ld_en           = 1'b1;
        end

        if (ld_en) begin
            tvalid_d = 1'b1;
            tdata_d  = mem[ld_bank][ld_b[BW-1:LOG2_NSUB]][ld_b[LOG2_NSUB-1:0]];
            tuser_d  = ld_b;
            tlast_d  = (ld_b == B_LAST);
        end
    end

    // Writer: frame sync on k==0, sequence check, bank claim (sees reader's release), drop accounting
    always_comb begin
        bank_d      = bank_r;
        wr_state_d  = wr_state_q;
        wr_bank_d   = wr_bank_q;
        exp_k_d     = exp_k_q;
        drop_cnt_d  = drop_cnt_q;
        sync_err_d  = sync_err_q;
        begin_frame = 1'b0;
        accept      = 1'b0;
        acc_bank    = wr_bank_q;
        drop_done   = 1'b0;

        if (in_valid) begin
            case (wr_state_q)
                WR_SYNC: begin
                    begin_frame = (in_k == '0);
                end
                WR_WRITE: begin
                    if (in_k == exp_k_q) begin
                        accept = 1'b1;
                    end else begin
                        // Broken frame is abandoned; a k==0 beat restarts right away
                        sync_err_d        = 1'b1;
                        bank_d[wr_bank_q] = BANK_EMPTY;
                        wr_state_d        = WR_SYNC;
                        begin_frame       = (in_k == '0);
                    end
                end
                WR_DROP: begin
                    if (in_k == K_LAST) begin
                        drop_done  = 1'b1;
                        wr_state_d = WR_SYNC;
                    end
                end
                default: wr_state_d = WR_SYNC;
            endcase
        end

        if (begin_frame) begin
            if (bank_d[0] == BANK_EMPTY) begin
                accept   = 1'b1;
                acc_bank = 1'b0;
            end else if (bank_d[1] == BANK_EMPTY) begin
                accept   = 1'b1;
                acc_bank = 1'b1;
            end else if (in_k == K_LAST) begin
                // Single-bin frame with no room ends in the beat it starts
                drop_done  = 1'b1;
                wr_state_d = WR_SYNC;
            end else begin
                wr_state_d = WR_DROP;
            end
        end

        if (accept) begin
            wr_bank_d = acc_bank;
            if (in_k == K_LAST) begin
                bank_d[acc_bank] = BANK_FULL;
                wr_state_d       = WR_SYNC;
            end else begin
                bank_d[acc_bank] = BANK_FILLING;
                exp_k_d          = in_k + K_WIDTH'(1);
                wr_state_d       = WR_WRITE;
            end
        end

        if (drop_done && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Bank memory write: one bin per lane per accepted beat
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[acc_bank][0][in_k[LOG2_NSUB-1:0]] <= in_data_0;
            mem[acc_bank][1][in_k[LOG2_NSUB-1:0]] <= in_data_1;
            mem[acc_bank][2][in_k[LOG2_NSUB-1:0]] <= in_data_2;
            mem[acc_bank][3][in_k[LOG2_NSUB-1:0]] <= in_data_3;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bank_q[0]  <= BANK_EMPTY;
            bank_q[1]  <= BANK_EMPTY;
            wr_state_q <= WR_SYNC;
            wr_bank_q  <= 1'b0;
            exp_k_q    <= '0;
            drop_cnt_q <= 16'd0;
            sync_err_q <= 1'b0;
            rd_state_q <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            tdata_q    <= 64'd0;
            tuser_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            wr_state_q <= wr_state_d;
            wr_bank_q  <= wr_bank_d;
            exp_k_q    <= exp_k_d;
            drop_cnt_q <= drop_cnt_d;
            sync_err_q <= sync_err_d;
            rd_state_q <= rd_state_d;
            rd_bank_q  <= rd_bank_d;
            tdata_q    <= tdata_d;
            tuser_q    <= tuser_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
        end
    end

    assign m_tdata        = tdata_q;
    assign m_tuser        = tuser_q;
    assign m_tvalid       = tvalid_q;
    assign m_tlast        = tlast_q;
    assign frame_drop_cnt = drop_cnt_q;
    assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_fft_bin_serializer.sv
// tb/tb_fft_bin_serializer.sv - randomized self-checking bench for fft_bin_serializer
module tb_fft_bin_serializer;

    localparam int LOG2_NSUB = 3;
    localparam int K_WIDTH   = 4;
    localparam int NSUB      = 8;
    localparam int NBIN      = 4 * NSUB;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [63:0]          in_data_0, in_data_1, in_data_2, in_data_3;
    logic [K_WIDTH-1:0]   in_k;
    logic                 in_valid;
    logic [63:0]          m_tdata;
    logic [LOG2_NSUB+1:0] m_tuser;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 m_tlast;
    logic [15:0]          frame_drop_cnt;
    logic                 sync_err;

    always #5 clk = ~clk;

    fft_bin_serializer #(
        .LOG2_NSUB(LOG2_NSUB),
        .K_WIDTH  (K_WIDTH)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_data_0     (in_data_0),
        .in_data_1     (in_data_1),
        .in_data_2     (in_data_2),
        .in_data_3     (in_data_3),
        .in_k          (in_k),
        .in_valid      (in_valid),
        .m_tdata       (m_tdata),
        .m_tuser       (m_tuser),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tlast       (m_tlast),
        .frame_drop_cnt(frame_drop_cnt),
        .sync_err      (sync_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frames are whole units; output is a queue of bins in natural order
    logic [63:0] beat_q [$];
    int          frame_e_q [$];
    logic [63:0] cur [4][NSUB];
    logic [63:0] drv_d [4];
    int          pos;
    int          x_edge;
    int          edge_n = 0;
    int          wmode;
    int          exp_k;
    int          drops;
    bit          serr;
    bit          after_reset;
    bit          exp_valid_now;
    bit          use_pattern;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        beat_q.delete();
        frame_e_q.delete();
        pos         = 0;
        x_edge      = 0;
        wmode       = 0;
        exp_k       = 0;
        drops       = 0;
        serr        = 1'b0;
        after_reset = 1'b1;
    endtask

    task automatic push_frame();
        for (int j = 0; j < 4; j++)
            for (int kk = 0; kk < NSUB; kk++)
                beat_q.push_back(cur[j][kk]);
        frame_e_q.push_back(edge_n + 1);
    endtask

    task automatic store_beat(input int k);
        for (int j = 0; j < 4; j++) cur[j][k] = drv_d[j];
    endtask

    // Effect of the upcoming clock edge: output side first so a released bank is reusable
    task automatic model_edge(input bit v, input int k, input bit rdy);
        bit start;
        after_reset = 1'b0;
        start = 1'b0;
        if (exp_valid_now && rdy) begin
            void'(beat_q.pop_front());
            pos++;
            if (pos == NBIN) begin
                pos = 0;
                void'(frame_e_q.pop_front());
                x_edge = edge_n + 1;
            end
        end
        if (v) begin
            if (wmode == 1) begin
                if (k == exp_k) begin
                    store_beat(k);
                    exp_k++;
                    if (k == NSUB - 1) begin
                        push_frame();
                        wmode = 0;
                    end
                end else begin
                    serr  = 1'b1;
                    wmode = 0;
                    start = (k == 0);
                end
            end else if (wmode == 2) begin
                if (k == NSUB - 1) begin
                    if (drops < 65535) drops++;
                    wmode = 0;
                end
            end else begin
                start = (k == 0);
            end
            if (start) begin
                if (frame_e_q.size() < 2) begin
                    store_beat(0);
                    exp_k = 1;
                    wmode = 1;
                end else begin
                    wmode = 2;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int thr;
        exp_valid_now = 1'b0;
        if (frame_e_q.size() > 0) begin
            thr = frame_e_q[0] + 1;
            if (x_edge > thr) thr = x_edge;
            exp_valid_now = (edge_n >= thr);
        end
        check("tvalid", 64'(m_tvalid), 64'(exp_valid_now));
        if (exp_valid_now) begin
            check("tdata", m_tdata, beat_q[0]);
            check("tuser", 64'(m_tuser), 64'(pos));
            check("tlast", 64'(m_tlast), 64'(pos == NBIN - 1));
        end
        check("sync_err", 64'(sync_err), 64'(serr));
        check("drop_cnt", 64'(frame_drop_cnt), 64'(drops));
        if (after_reset) begin
            check("rst_tdata", m_tdata, 64'd0);
            check("rst_tuser", 64'(m_tuser), 64'd0);
            check("rst_tlast", 64'(m_tlast), 64'd0);
        end
    endtask

    task automatic step(input bit v, input int k, input bit rdy, input bit rn);
        @(negedge clk);
        check_outputs();
        for (int j = 0; j < 4; j++)
            drv_d[j] = use_pattern ? {32'(j), 32'(k)} : {$urandom, $urandom};
        resetn    = rn;
        in_valid  = v;
        in_k      = K_WIDTH'(k);
        m_tready  = rdy;
        in_data_0 = drv_d[0];
        in_data_1 = drv_d[1];
        in_data_2 = drv_d[2];
        in_data_3 = drv_d[3];
        if (!rn) model_reset();
        else     model_edge(v, k, rdy);
        edge_n++;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic send_frame(input bit rdy);
        for (int k = 0; k < NSUB; k++) step(1, k, rdy, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 1);
    endtask

    initial begin
        bit tog;
        int kc;
        int k;
        bit v;
        bit rdy;
        int rdy_bias;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_k      = '0;
        m_tready  = 1'b0;
        in_data_0 = 64'd0;
        in_data_1 = 64'd0;
        in_data_2 = 64'd0;
        in_data_3 = 64'd0;
        model_reset();
        use_pattern = 1'b1;
        do_reset();

        // Single frame, always ready
        send_frame(1'b1);
        idle(40);

        // Single frame, ready toggling every cycle
        tog = 1'b1;
        for (int kk = 0; kk < NSUB; kk++) begin
            step(1, kk, tog, 1);
            tog = ~tog;
        end
        for (int i = 0; i < 80; i++) begin
            step(0, 0, tog, 1);
            tog = ~tog;
        end

        // Three frames against a stalled sink: two buffered, one dropped
        for (int f = 0; f < 3; f++) send_frame(1'b0);
        step(0, 0, 0, 1);
        check("drop_cnt_3frames", 64'(frame_drop_cnt), 64'd1);
        idle(70);

        // Bank released by the final handshake is claimed in the same cycle
        do_reset();
        send_frame(1'b0);
        send_frame(1'b0);
        for (int s = 1; s <= 60; s++) step(1, s % NSUB, 1, 1);
        idle(70);

        // Sequence error 0,1,2,5 followed by a clean frame
        send_frame(1'b1);
        idle(40);
        step(1, 0, 1, 1);
        step(1, 1, 1, 1);
        step(1, 2, 1, 1);
        step(1, 5, 1, 1);
        send_frame(1'b1);
        idle(40);

        // Partial frame after reset is ignored
        do_reset();
        for (int kk = 3; kk < NSUB; kk++) step(1, kk, 1, 1);
        send_frame(1'b1);
        idle(40);

        // Reset while bin 10 is being presented
        send_frame(1'b1);
        for (int i = 0; i < 60; i++) begin
            if (pos == 10 && frame_e_q.size() > 0) break;
            step(0, 0, 1, 1);
        end
        check("pre_reset_pos", 64'(pos), 64'd10);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        send_frame(1'b1);
        idle(40);

        // Randomized traffic: gaps, sequence glitches, bursty backpressure, occasional reset
        use_pattern = 1'b0;
        do_reset();
        kc = 0;
        rdy_bias = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) rdy_bias = $urandom_range(0, 4);
            v   = ($urandom_range(0, 9) != 0);
            k   = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 15)) : kc;
            rdy = (int'($urandom_range(0, 3)) < rdy_bias);
            if (v) kc = (k + 1) % NSUB;
            if ($urandom_range(0, 799) == 0) step(0, 0, rdy, 0);
            else                             step(v, k, rdy, 1);
        end
        idle(100);
        step(0, 0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
